mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one synchronous program memory (1-cycle read latency) between the 8008 core
//  (CPU port) and a program loader/debug port (LD port). Sequences every access as a
//  fixed 4-cycle transaction, with round-robin tie-break. LD may lock out the CPU while
//  it streams in a new program. Sits between core/loader and the memory bank.
// PARAMETERS
//  ADDR_WIDTH  14  address bits on both ports and on the memory
//  DATA_WIDTH  8   data bits
// PORTS
//  clk          in   1   system clock; all state changes on rising edge
//  reset        in   1   synchronous reset, active-high
//  cpu_req      in   1   CPU request; level, held until cpu_ack
//  cpu_we       in   1   1=write, 0=read; held with cpu_req
//  cpu_address  in   AW  CPU address; held with cpu_req
//  cpu_wdata    in   DW  CPU write data; held with cpu_req
//  cpu_rdata    out  DW  CPU read data; valid while cpu_ack=1
//  cpu_ack      out  1   one-cycle completion pulse
//  ld_req/ld_we/ld_address/ld_wdata  in   1/1/AW/DW  loader request; same rules as CPU
//  ld_rdata     out  DW  loader read data; valid while ld_ack=1
//  ld_ack       out  1   one-cycle completion pulse
//  ld_lock      in   1   1=CPU requests not granted (CPU stalls)
//  mem_address  out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_we       out  1   memory write strobe
//  mem_rdata    in   DW  memory read data, valid the cycle after the address is presented
//  busy         out  1   1 when FSM is not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=CPU; all outputs 0 (cpu_ack, ld_ack, mem_we, busy,
//   mem_address, mem_wdata, cpu_rdata, ld_rdata).
//  FSM IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE. All outputs registered.
//   IDLE (cycle N): select requester and latch its we/address/wdata into mem_* regs.
//     Eligible: ld_req; cpu_req only when ld_lock=0. None eligible -> stay IDLE.
//   ACCESS (N+1): mem_address/mem_wdata valid; mem_we=latched we for this cycle only.
//   CAPTURE (N+2): mem_rdata registered into selected port's rdata (reads only;
//     writes leave rdata unchanged); mem_we=0.
//   ACK (N+3): selected port's ack=1 for exactly this cycle; other ack stays 0.
//  Latency: req sampled at edge ending N -> ack high in N+3.
//   Back-to-back from one port: one access per 4 cycles.
//  Requester must drop req (or present a new request) on the edge ending its ack cycle.
//   req still high in the following IDLE is a new request.
//  Arbitration, both eligible in IDLE: grant port != last_grant.
//   last_grant updates on every grant. After reset the first tie goes to LD.
//  mem_address/mem_wdata hold their values from ACCESS through ACK and in IDLE until the
//   next grant.
//  ld_lock rising while a CPU access is in flight: that access completes normally.
//   Lock affects grants only in IDLE.
//  ld_lock=1 and only cpu_req: stay IDLE; busy=0; no ack.
//  Request inputs changing after the grant edge are ignored until the next IDLE.
//  Address is used unmodified; full 2^AW space, no decode, no wrap logic.
//  Reset mid-transaction: next cycle IDLE, mem_we=0, no ack issued.
//   A write already strobed in ACCESS stays committed.
// TESTING
//  1. LD write 0x0005<-0x5A then LD read 0x0005: ld_ack at N+3 each; ld_rdata=0x5A; mem_we high exactly 1 cycle.
//  2. cpu_req and ld_req rise in the same cycle after reset: LD granted first. CPU ack 4 cycles after LD ack. Both held high: alternate LD,CPU,LD.
//  3. ld_lock=1, cpu_req held 20 cycles: no cpu_ack, busy=0. Drop lock: cpu_ack 3 cycles after the first unlocked IDLE.
//  4. CPU read of 0x3FFF in flight, ld_lock asserted in ACCESS: cpu_ack still at N+3 with the correct data; next grant to LD.
//  5. reset asserted in CAPTURE of a CPU read: no cpu_ack; all outputs 0 next cycle; a new LD read then completes normally.
//  6. CPU write 0x0010<-0xA5, then CPU read: cpu_rdata=0xA5; ld_rdata unchanged; ld_ack never asserted.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, loader and memory-side signals of the program memory arbiter.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_address;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic [DATA_WIDTH-1:0] ld_rdata;
    logic                  ld_ack;
    logic                  ld_lock;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_address, cpu_wdata, ld_req, ld_we, ld_address, ld_wdata,
               ld_lock, mem_rdata,
        output cpu_rdata, cpu_ack, ld_rdata, ld_ack, mem_address, mem_wdata, mem_we, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_address, cpu_wdata, ld_req, ld_we, ld_address, ld_wdata,
               ld_lock, mem_rdata,
        input  cpu_rdata, cpu_ack, ld_rdata, ld_ack, mem_address, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares a 1-cycle-latency program memory between CPU and loader via fixed 4-cycle transactions.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
) (
    input logic             clk,
    input logic             reset,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_e;

    state_e                state_q, state_d;
    logic                  sel_ld_q, sel_ld_d;
    logic                  last_ld_q, last_ld_d;
    logic                  we_q, we_d;
    logic                  mem_we_q, mem_we_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  ld_ack_q, ld_ack_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;
    logic                  cpu_ok, grant_ld;

    always_comb begin
        cpu_ok      = bus.cpu_req & ~bus.ld_lock;
        grant_ld    = bus.ld_req & (~cpu_ok | ~last_ld_q);
        state_d     = state_q;
        sel_ld_d    = sel_ld_q;
        last_ld_d   = last_ld_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        ld_ack_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        case (state_q)
            IDLE: if (bus.ld_req | cpu_ok) begin
                state_d   = ACCESS;
                sel_ld_d  = grant_ld;
                last_ld_d = grant_ld;
                we_d      = grant_ld ? bus.ld_we : bus.cpu_we;
                addr_d    = grant_ld ? bus.ld_address : bus.cpu_address;
                wdata_d   = grant_ld ? bus.ld_wdata : bus.cpu_wdata;
                mem_we_d  = we_d;
            end
            ACCESS: state_d = CAPTURE;
            CAPTURE: begin
                state_d     = ACK;
                cpu_rdata_d = (!we_q && !sel_ld_q) ? bus.mem_rdata : cpu_rdata_q;
                ld_rdata_d  = (!we_q && sel_ld_q) ? bus.mem_rdata : ld_rdata_q;
                cpu_ack_d   = ~sel_ld_q;
                ld_ack_d    = sel_ld_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_ld_q    <= 1'b0;
            last_ld_q   <= 1'b0;
            we_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_ld_q    <= sel_ld_d;
            last_ld_q   <= last_ld_d;
            we_q        <= we_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.ld_rdata    = ld_rdata_q;
    assign bus.ld_ack      = ld_ack_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenario tests of the arbiter against a synchronous memory model.
module tb_mem_bus_arbiter;
    logic clk;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    int   we_cnt = 0;
    int   ld_ack_cnt = 0;
    int   cpu_ack_cnt = 0;
    logic [7:0] mem [0:16383];

    mem_bus_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_address] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_address];
    end

    always @(negedge clk) begin
        if (bus.mem_we) we_cnt++;
        if (bus.ld_ack) ld_ack_cnt++;
        if (bus.cpu_ack) cpu_ack_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit ld, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ld ? bus.ld_ack : bus.cpu_ack) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.cpu_ack, bus.ld_ack, bus.mem_we, bus.busy, bus.mem_address, bus.mem_wdata,
             bus.cpu_rdata, bus.ld_rdata} !== '0)
            $display("FAIL reset_outputs: some output nonzero ack=%b/%b we=%b busy=%b", bus.cpu_ack,
                     bus.ld_ack, bus.mem_we, bus.busy);
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", bus.busy);
        else passed++;
    endtask

    task automatic test_ld_write_read;
        int n;
        int w0;
        w0 = we_cnt;
        bus.ld_we = 1'b1;
        bus.ld_address = 14'h0005;
        bus.ld_wdata = 8'h5A;
        bus.ld_req = 1'b1;
        wait_ack(1'b1, n);
        checks++;
        if (n !== 3) $display("FAIL ld_write_latency got %0d want 3", n);
        else passed++;
        checks++;
        if (we_cnt - w0 !== 1) $display("FAIL ld_write_we_cycles got %0d want 1", we_cnt - w0);
        else passed++;
        checks++;
        if ({bus.mem_address, bus.mem_wdata} !== {14'h0005, 8'h5A})
            $display("FAIL ld_write_hold got %h/%h want 0005/5a", bus.mem_address, bus.mem_wdata);
        else passed++;
        bus.ld_req = 1'b0;
        tick();
        checks++;
        if (bus.ld_ack !== 1'b0) $display("FAIL ld_ack_pulse got %b want 0", bus.ld_ack);
        else passed++;
        bus.ld_we = 1'b0;
        bus.ld_req = 1'b1;
        wait_ack(1'b1, n);
        checks++;
        if (n !== 3) $display("FAIL ld_read_latency got %0d want 3", n);
        else passed++;
        checks++;
        if (bus.ld_rdata !== 8'h5A) $display("FAIL ld_read_data got %h want 5a", bus.ld_rdata);
        else passed++;
        bus.ld_req = 1'b0;
        tick();
    endtask

    task automatic test_arbitration;
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_address = 14'h0005;
        bus.ld_we = 1'b0;
        bus.ld_address = 14'h0005;
        bus.cpu_req = 1'b1;
        bus.ld_req = 1'b1;
        wait_ack(1'b1, n);
        checks++;
        if (n !== 3) $display("FAIL arb_first_ld got %0d want 3", n);
        else passed++;
        checks++;
        if (bus.cpu_ack !== 1'b0) $display("FAIL arb_first_cpu_ack got %b want 0", bus.cpu_ack);
        else passed++;
        wait_ack(1'b0, n);
        checks++;
        if (n !== 4) $display("FAIL arb_then_cpu got %0d want 4", n);
        else passed++;
        checks++;
        if (bus.cpu_rdata !== 8'h5A) $display("FAIL arb_cpu_data got %h want 5a", bus.cpu_rdata);
        else passed++;
        wait_ack(1'b1, n);
        checks++;
        if (n !== 4) $display("FAIL arb_then_ld got %0d want 4", n);
        else passed++;
        bus.cpu_req = 1'b0;
        bus.ld_req = 1'b0;
        tick();
    endtask

    task automatic test_lock;
        int n;
        int bad;
        bad = 0;
        bus.ld_lock = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_address = 14'h0005;
        bus.cpu_req = 1'b1;
        repeat (20) begin
            tick();
            if (bus.busy !== 1'b0 || bus.cpu_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL lock_stall bad cycles got %0d want 0", bad);
        else passed++;
        bus.ld_lock = 1'b0;
        wait_ack(1'b0, n);
        checks++;
        if (n !== 3) $display("FAIL lock_release_latency got %0d want 3", n);
        else passed++;
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_lock_inflight;
        int n;
        bus.cpu_we = 1'b0;
        bus.cpu_address = 14'h3FFF;
        bus.cpu_req = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL inflight_busy got %b want 1", bus.busy);
        else passed++;
        bus.ld_lock = 1'b1;
        bus.ld_we = 1'b0;
        bus.ld_address = 14'h0005;
        bus.ld_req = 1'b1;
        wait_ack(1'b0, n);
        checks++;
        if (n !== 2) $display("FAIL inflight_cpu_ack got %0d want 2", n);
        else passed++;
        checks++;
        if (bus.cpu_rdata !== 8'hC3) $display("FAIL inflight_cpu_data got %h want c3", bus.cpu_rdata);
        else passed++;
        wait_ack(1'b1, n);
        checks++;
        if (n !== 4) $display("FAIL inflight_next_ld got %0d want 4", n);
        else passed++;
        bus.cpu_req = 1'b0;
        bus.ld_req = 1'b0;
        bus.ld_lock = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int n;
        int c0;
        bus.cpu_we = 1'b0;
        bus.cpu_address = 14'h0005;
        bus.cpu_req = 1'b1;
        tick();
        tick();
        c0 = cpu_ack_cnt;
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if ({bus.cpu_ack, bus.ld_ack, bus.mem_we, bus.busy, bus.mem_address, bus.mem_wdata,
             bus.cpu_rdata, bus.ld_rdata} !== '0)
            $display("FAIL midreset_outputs: nonzero ack=%b busy=%b rdata=%h addr=%h", bus.cpu_ack,
                     bus.busy, bus.cpu_rdata, bus.mem_address);
        else passed++;
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (cpu_ack_cnt !== c0) $display("FAIL midreset_no_ack got %0d acks want 0", cpu_ack_cnt - c0);
        else passed++;
        bus.ld_we = 1'b0;
        bus.ld_address = 14'h0005;
        bus.ld_req = 1'b1;
        wait_ack(1'b1, n);
        checks++;
        if (n !== 3 || bus.ld_rdata !== 8'h5A)
            $display("FAIL midreset_ld_read got lat %0d data %h want 3 5a", n, bus.ld_rdata);
        else passed++;
        bus.ld_req = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write_read;
        int n;
        int l0;
        logic [7:0] lr;
        l0 = ld_ack_cnt;
        lr = bus.ld_rdata;
        bus.cpu_we = 1'b1;
        bus.cpu_address = 14'h0010;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_req = 1'b1;
        wait_ack(1'b0, n);
        checks++;
        if (n !== 3 || mem[16] !== 8'hA5)
            $display("FAIL cpu_write got lat %0d mem %h want 3 a5", n, mem[16]);
        else passed++;
        bus.cpu_req = 1'b0;
        tick();
        bus.cpu_we = 1'b0;
        bus.cpu_req = 1'b1;
        wait_ack(1'b0, n);
        checks++;
        if (n !== 3 || bus.cpu_rdata !== 8'hA5)
            $display("FAIL cpu_read got lat %0d data %h want 3 a5", n, bus.cpu_rdata);
        else passed++;
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b0) $display("FAIL cpu_ack_pulse got %b want 0", bus.cpu_ack);
        else passed++;
        checks++;
        if (bus.ld_rdata !== lr) $display("FAIL cpu_ld_rdata got %h want %h", bus.ld_rdata, lr);
        else passed++;
        checks++;
        if (ld_ack_cnt !== l0) $display("FAIL cpu_no_ld_ack got %0d want 0", ld_ack_cnt - l0);
        else passed++;
    endtask

    initial begin
        mem[14'h3FFF] = 8'hC3;
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_wdata = '0;
        bus.ld_req = 1'b0;
        bus.ld_we = 1'b0;
        bus.ld_address = '0;
        bus.ld_wdata = '0;
        bus.ld_lock = 1'b0;
        test_reset();
        test_ld_write_read();
        test_arbitration();
        test_lock();
        test_lock_inflight();
        test_reset_mid();
        test_cpu_write_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
